sysinfo_health_poller: RTL and testbench
========================================

Name: sysinfo_health_poller

Overview:
- APB requester that periodically sweeps the system-info sensor registers (fan0/fan1 RPM, die temp, core/RAM/aux voltages) over a 16-bit APB link.
- Caches the latest values, compares each against per-channel min/max thresholds, and raises sticky alarm and bus-error flags.
- Sits between the management clock domain and the system-info APB completer. Firmware reads cached values and alarms with no APB traffic of its own.

Parameters:
- POLL_INTERVAL, 1000000: cycles between sweep starts. Minimum 8.
- TIMEOUT, 255: maximum cycles waiting in ACCESS for pready before aborting. Minimum 1.
- BASE_ADDR, 8'h10: APB address of channel 0. Channel n is at BASE_ADDR + 2n.

Ports:
- clk  in  1  Management clock; also the APB pclk.
- rst  in  1  Synchronous, active-high reset.
- enable  in  1  Enables periodic sweeps.
- poll_now  in  1  Single-cycle pulse that requests an immediate sweep.
- alarm_clear  in  1  Single-cycle pulse that clears all alarm and bus_error bits.
- thresh_lo  in  96  Six 16-bit unsigned minimums; channel n occupies [16n+15:16n].
- thresh_hi  in  96  Six 16-bit unsigned maximums; same packing.
- psel, penable, pwrite  out  1 each  APB control signals. pwrite is tied to 0.
- paddr  out  8  APB address.
- prdata  in  16  APB read data.
- pready, pslverr  in  1 each  APB completer responses.
- sample  out  96  Cached channel values; same packing as the thresholds.
- sample_valid  out  6  Bit n is set once channel n has had at least one good read.
- alarm  out  6  Sticky out-of-range flags.
- bus_error  out  6  Sticky pslverr/timeout flags.
- sweep_done  out  1  Single-cycle pulse at the end of each sweep.
- busy  out  1  High while any state other than IDLE is active.

Behaviour:
- Reset state:
  - FSM in IDLE; interval counter = 0; chan = 0.
  - psel, penable, busy, sweep_done = 0; paddr = 0.
  - sample, sample_valid, alarm, bus_error = 0.
  - Reset during an active transfer drops psel/penable on the next edge.
- Interval counter:
  - Increments in IDLE while enable = 1; held at 0 while enable = 0.
  - A sweep starts when the counter reaches POLL_INTERVAL-1, or on the cycle after poll_now when IDLE.
  - The counter clears when a sweep starts.
  - poll_now arriving while busy is latched once, and a sweep starts right after the current one ends.
  - poll_now works even when enable = 0.
- FSM states: IDLE -> SETUP -> ACCESS -> (NEXT -> SETUP | DONE -> IDLE).
  - SETUP (1 cycle): psel = 1, penable = 0, paddr = BASE_ADDR + 2*chan.
  - ACCESS: psel = 1, penable = 1. Exits on the first cycle with pready = 1, or when the wait counter reaches TIMEOUT.
  - NEXT (1 cycle): psel = 0. If chan == 5, go to DONE; otherwise chan++ and go to SETUP.
  - DONE (1 cycle): sweep_done = 1, chan = 0, then IDLE.
  - paddr holds its value from SETUP through ACCESS.
  - Minimum sweep time: 6*3 + 1 = 19 cycles.
- Completion in ACCESS:
  - pready = 1 with pslverr = 0: sample[n] <= prdata and sample_valid[n] <= 1. On the same edge, alarm[n] is set if prdata < thresh_lo[n] or prdata > thresh_hi[n] (unsigned compare; bounds are inclusive-OK).
  - pready = 1 with pslverr = 1: bus_error[n] <= 1; sample[n] is unchanged.
  - Timeout: psel/penable drop; bus_error[n] <= 1; sample[n] is unchanged; the sweep continues with the next channel.
- alarm_clear clears all alarm and bus_error bits. If a set and the clear occur on the same cycle, the set wins for that bit. Samples are never cleared except by reset.
- enable falling mid-sweep: the current sweep runs to completion (APB transfers are never truncated), then the FSM stays in IDLE.
- Thresholds are sampled combinationally at the completion edge only.
- Alarms reflect only the sample just read.

Optional Feature:
- Macro: SYSINFO_HEALTH_POLLER_DEBOUNCE_EN.
- Defined:
  - Each channel has a 2-bit saturating count of consecutive out-of-range good reads.
  - alarm[n] sets only when the count reaches 3. An in-range read resets the count to 0.
  - Errored or timed-out reads leave the count unchanged.
- Undefined: alarm sets on the first out-of-range read and no counters are instantiated.

Decomposition:
- Package sysinfo_health_pkg holds:
  - NUM_CHAN = 6.
  - The channel index enum (CH_FAN0, CH_FAN1, CH_TEMP, CH_VCORE, CH_VRAM, CH_VAUX).
  - The FSM state enum.
  - The threshold/sample packing helper width SAMPLE_W = 16.
- One natural sub-module: sysinfo_threshold_check. It is a per-channel compare plus the optional debounce counter, instantiated six times.

Test Plan:
- Reset, then enable = 1 with POLL_INTERVAL = 20 and a completer returning 0x1000 + address with zero wait states:
  - First psel appears at cycle 20 with paddr = 0x10; reads follow at 0x12…0x1a.
  - sweep_done is high on the 19th cycle of the sweep; sample holds 0x1010…0x101a; sample_valid = 6'h3f.
- thresh_lo[2] = 0x2000 with temp read = 0x1fff: alarm = 6'b000100. alarm_clear on the same cycle as the completion edge leaves alarm[2] = 1.
- Completer returns pslverr = 1 at paddr 0x16: bus_error = 6'b001000; sample[3] keeps its previous value; the sweep still reads 0x18 and 0x1a.
- Completer never asserts pready at 0x12 with TIMEOUT = 4: ACCESS lasts 4 cycles, then psel falls; bus_error[1] = 1; the next SETUP is at 0x14.
- poll_now issued mid-sweep, then enable dropped: the current sweep finishes, exactly one extra sweep runs, then the FSM stays IDLE with no further psel.
- With SYSINFO_HEALTH_POLLER_DEBOUNCE_EN defined, vaux is out of range for 2 sweeps then in range: alarm[5] stays 0. For 3 consecutive sweeps: alarm[5] = 1 after the third.

Source files
------------

// File: rtl/sysinfo_health_poller_pkg.sv
// Shared types for the system-info health poller: channel map, FSM states, sample width.
// Pure declarations; no logic, no latency, no flow control.
package sysinfo_health_pkg;

  localparam int NUM_CHAN = 6;
  localparam int SAMPLE_W = 16;

  typedef enum logic [2:0] {
    CH_FAN0  = 3'd0,
    CH_FAN1  = 3'd1,
    CH_TEMP  = 3'd2,
    CH_VCORE = 3'd3,
    CH_VRAM  = 3'd4,
    CH_VAUX  = 3'd5
  } chan_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_NEXT,
    ST_DONE
  } state_e;

  // Registers are 16-bit, so channels sit on even byte addresses.
  function automatic logic [7:0] chan_addr(input logic [7:0] base, input chan_e ch);
    return base + {4'd0, ch, 1'b0};
  endfunction

endpackage

// File: rtl/sysinfo_health_poller_if.sv
// APB3 read-only link between the health poller (master) and the sysinfo completer (slave).
// Signal bundle only; pready provides the completer backpressure.
interface sysinfo_health_poller_if;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [15:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/sysinfo_health_poller_threshold_check.sv
// Per-channel min/max check; alarm_set is combinational so it lands on the completion edge.
// With SYSINFO_HEALTH_POLLER_DEBOUNCE_EN a 2-bit run counter delays the alarm to the 3rd bad read.
module sysinfo_threshold_check
  import sysinfo_health_pkg::*;
(
`ifdef SYSINFO_HEALTH_POLLER_DEBOUNCE_EN
  input  logic                clk,
  input  logic                rst,
  input  logic                good_vld,
`endif
  input  logic [SAMPLE_W-1:0] rd_dat,
  input  logic [SAMPLE_W-1:0] lo_dat,
  input  logic [SAMPLE_W-1:0] hi_dat,
  output logic                alarm_set
);

  logic out_of_range;

  assign out_of_range = (rd_dat < lo_dat) || (rd_dat > hi_dat);

`ifdef SYSINFO_HEALTH_POLLER_DEBOUNCE_EN
  logic [1:0] run_q;
  logic [1:0] run_d;

  // Only good reads move the counter; errored or timed-out reads leave it alone.
  always_comb begin
    run_d = run_q;
    if (good_vld) begin
      if (!out_of_range) begin
        run_d = 2'd0;
      end else if (run_q != 2'd3) begin
        run_d = run_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 2'd0;
    end else begin
      run_q <= run_d;
    end
  end

  // Two prior bad reads plus this one reaches a count of three.
  assign alarm_set = out_of_range && (run_q >= 2'd2);
`else
  assign alarm_set = out_of_range;
`endif

endmodule

// File: rtl/sysinfo_health_poller.sv
// APB requester that sweeps six sysinfo sensor registers, caches them and flags range/bus faults.
// Sweep is 19 cycles minimum; pready stalls ACCESS up to TIMEOUT cycles. Option: SYSINFO_HEALTH_POLLER_DEBOUNCE_EN.
module sysinfo_health_poller
  import sysinfo_health_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL = 1000000,
  parameter int unsigned TIMEOUT       = 255,
  parameter logic [7:0]  BASE_ADDR     = 8'h10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         poll_now,
  input  logic                         alarm_clear,
  input  logic [NUM_CHAN*SAMPLE_W-1:0] thresh_lo,
  input  logic [NUM_CHAN*SAMPLE_W-1:0] thresh_hi,
  sysinfo_health_poller_if.master      apb,
  output logic [NUM_CHAN*SAMPLE_W-1:0] sample,
  output logic [NUM_CHAN-1:0]          sample_valid,
  output logic [NUM_CHAN-1:0]          alarm,
  output logic [NUM_CHAN-1:0]          bus_error,
  output logic                         sweep_done,
  output logic                         busy
);

  localparam int CNT_W  = $clog2(POLL_INTERVAL);
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                              state_q, state_d;
  chan_e                               chan_q, chan_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [WAIT_W-1:0]                   wait_q, wait_d;
  logic                                pend_q, pend_d;
  logic [7:0]                          paddr_q, paddr_d;
  logic [NUM_CHAN-1:0][SAMPLE_W-1:0]   sample_q, sample_d;
  logic [NUM_CHAN-1:0]                 valid_q, valid_d;
  logic [NUM_CHAN-1:0]                 alarm_q, alarm_d;
  logic [NUM_CHAN-1:0]                 berr_q, berr_d;
  logic [NUM_CHAN-1:0]                 alarm_set;
  logic                                start_sweep;

`ifdef SYSINFO_HEALTH_POLLER_DEBOUNCE_EN
  logic [NUM_CHAN-1:0]                 good_vld;

  assign good_vld = (state_q == ST_ACCESS && apb.pready && !apb.pslverr)
                  ? ({{(NUM_CHAN-1){1'b0}}, 1'b1} << chan_q) : '0;
`endif

  for (genvar n = 0; n < NUM_CHAN; n++) begin : g_chk
    sysinfo_threshold_check u_chk (
`ifdef SYSINFO_HEALTH_POLLER_DEBOUNCE_EN
      .clk      (clk),
      .rst      (rst),
      .good_vld (good_vld[n]),
`endif
      .rd_dat   (apb.prdata),
      .lo_dat   (thresh_lo[n*SAMPLE_W +: SAMPLE_W]),
      .hi_dat   (thresh_hi[n*SAMPLE_W +: SAMPLE_W]),
      .alarm_set(alarm_set[n])
    );
  end

  assign start_sweep = poll_now || pend_q ||
                       (enable && (cnt_q == CNT_W'(POLL_INTERVAL - 1)));

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    pend_d   = pend_q;
    paddr_d  = paddr_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    alarm_d  = alarm_clear ? '0 : alarm_q;
    berr_d   = alarm_clear ? '0 : berr_q;

    // A request during a sweep is remembered once and served right after it.
    if (poll_now && state_q != ST_IDLE) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = enable ? cnt_q + CNT_W'(1) : '0;
        if (start_sweep) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          pend_d  = 1'b0;
          chan_d  = CH_FAN0;
          paddr_d = chan_addr(BASE_ADDR, CH_FAN0);
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        wait_d  = '0;
      end
      ST_ACCESS: begin
        if (apb.pready) begin
          state_d = ST_NEXT;
          if (apb.pslverr) begin
            berr_d[chan_q] = 1'b1;
          end else begin
            sample_d[chan_q] = apb.prdata;
            valid_d[chan_q]  = 1'b1;
            if (alarm_set[chan_q]) begin
              alarm_d[chan_q] = 1'b1;
            end
          end
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d        = ST_NEXT;
          berr_d[chan_q] = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_NEXT: begin
        if (chan_q == CH_VAUX) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETUP;
          chan_d  = chan_e'(chan_q + 3'd1);
          paddr_d = chan_addr(BASE_ADDR, chan_e'(chan_q + 3'd1));
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        chan_d  = CH_FAN0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      chan_q   <= CH_FAN0;
      cnt_q    <= '0;
      wait_q   <= '0;
      pend_q   <= 1'b0;
      paddr_q  <= '0;
      sample_q <= '0;
      valid_q  <= '0;
      alarm_q  <= '0;
      berr_q   <= '0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      pend_q   <= pend_d;
      paddr_q  <= paddr_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      alarm_q  <= alarm_d;
      berr_q   <= berr_d;
    end
  end

  assign apb.psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign apb.penable = (state_q == ST_ACCESS);
  assign apb.pwrite  = 1'b0;
  assign apb.paddr   = paddr_q;

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign alarm        = alarm_q;
  assign bus_error    = berr_q;
  assign sweep_done   = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sysinfo_health_poller.sv
// Directed bench for sysinfo_health_poller with a behavioural APB completer (0x1000 + paddr + offset).
// POLL_INTERVAL = 20, TIMEOUT = 4; debounce checks apply when SYSINFO_HEALTH_POLLER_DEBOUNCE_EN is set.
module tb_sysinfo_health_poller;
  import sysinfo_health_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        poll_now;
  logic        alarm_clear;
  logic [95:0] thresh_lo;
  logic [95:0] thresh_hi;
  logic [95:0] sample;
  logic [5:0]  sample_valid;
  logic [5:0]  alarm;
  logic [5:0]  bus_error;
  logic        sweep_done;
  logic        busy;

  logic        ovr_en, err_en, hang_en;
  logic [7:0]  ovr_addr, err_addr, hang_addr;
  logic [15:0] ovr_dat, data_ofs;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done, n_start, n;

  sysinfo_health_poller_if apb ();

  sysinfo_health_poller #(
    .POLL_INTERVAL(20),
    .TIMEOUT      (4),
    .BASE_ADDR    (8'h10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .poll_now    (poll_now),
    .alarm_clear (alarm_clear),
    .thresh_lo   (thresh_lo),
    .thresh_hi   (thresh_hi),
    .apb         (apb),
    .sample      (sample),
    .sample_valid(sample_valid),
    .alarm       (alarm),
    .bus_error   (bus_error),
    .sweep_done  (sweep_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    apb.prdata  = 16'h1000 + {8'h00, apb.paddr} + data_ofs;
    if (ovr_en && apb.paddr == ovr_addr) apb.prdata = ovr_dat;
    apb.pready  = apb.psel && apb.penable && !(hang_en && apb.paddr == hang_addr);
    apb.pslverr = apb.pready && err_en && (apb.paddr == err_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_poll();
    poll_now = 1'b1;
    tick();
    poll_now = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (sweep_done !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk(tag, 96'(sweep_done), 96'(1));
    tick();
  endtask

  task automatic clear_flags();
    alarm_clear = 1'b1;
    tick();
    alarm_clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; poll_now = 1'b0; alarm_clear = 1'b0;
    thresh_lo = '0; thresh_hi = '1;
    ovr_en = 1'b0; err_en = 1'b0; hang_en = 1'b0;
    ovr_addr = 8'h00; err_addr = 8'h00; hang_addr = 8'h00;
    ovr_dat = 16'h0000; data_ofs = 16'h0000;
    repeat (3) tick();

    chk("rst_psel",   96'(apb.psel), 96'(0));
    chk("rst_pen",    96'(apb.penable), 96'(0));
    chk("rst_pwrite", 96'(apb.pwrite), 96'(0));
    chk("rst_paddr",  96'(apb.paddr), 96'(0));
    chk("rst_busy",   96'(busy), 96'(0));
    chk("rst_done",   96'(sweep_done), 96'(0));
    chk("rst_sample", sample, 96'(0));
    chk("rst_flags",  96'({sample_valid, alarm, bus_error}), 96'(0));

    // Periodic sweep: first SETUP 20 cycles after enable.
    rst = 1'b0; enable = 1'b1;
    for (int i = 0; i < 19; i++) tick();
    chk("pre_psel", 96'(apb.psel), 96'(0));
    tick();
    chk("setup0", 96'({apb.psel, apb.penable, apb.paddr}), 96'({2'b10, 8'h10}));
    tick();
    chk("access0", 96'({apb.psel, apb.penable, apb.paddr}), 96'({2'b11, 8'h10}));
    tick(); tick();
    for (int k = 1; k < 6; k++) begin
      chk("setup_k", 96'({apb.psel, apb.penable, apb.paddr}), 96'({2'b10, 8'(8'h10 + 2 * k)}));
      tick(); tick(); tick();
    end
    chk("done19", 96'({sweep_done, busy}), 96'(2'b11));
    enable = 1'b0;
    tick();
    chk("post_idle", 96'({sweep_done, busy}), 96'(2'b00));
    chk("sample1", sample, {16'h101a, 16'h1018, 16'h1016, 16'h1014, 16'h1012, 16'h1010});
    chk("valid1", 96'(sample_valid), 96'(6'h3f));
    chk("noalarm1", 96'({alarm, bus_error}), 96'(0));

`ifdef SYSINFO_HEALTH_POLLER_DEBOUNCE_EN
    thresh_lo[5*16 +: 16] = 16'h2000;
    start_poll(); wait_done("db_a1"); chk("db_alarm_a1", 96'(alarm), 96'(0));
    start_poll(); wait_done("db_a2"); chk("db_alarm_a2", 96'(alarm), 96'(0));
    thresh_lo[5*16 +: 16] = 16'h0000;
    start_poll(); wait_done("db_a3"); chk("db_alarm_a3", 96'(alarm), 96'(0));
    thresh_lo[5*16 +: 16] = 16'h2000;
    start_poll(); wait_done("db_b1"); chk("db_alarm_b1", 96'(alarm), 96'(0));
    start_poll(); wait_done("db_b2"); chk("db_alarm_b2", 96'(alarm), 96'(0));
    start_poll(); wait_done("db_b3"); chk("db_alarm_b3", 96'(alarm), 96'(6'b100000));
    thresh_lo[5*16 +: 16] = 16'h0000;
`else
    // Temp below minimum, fan1 above maximum, vram exactly on both bounds.
    thresh_lo[2*16 +: 16] = 16'h2000;
    ovr_en = 1'b1; ovr_addr = 8'h14; ovr_dat = 16'h1fff;
    thresh_hi[1*16 +: 16] = 16'h1011;
    thresh_lo[4*16 +: 16] = 16'h1018;
    thresh_hi[4*16 +: 16] = 16'h1018;
    start_poll(); wait_done("alarm_a");
    chk("alarm_a", 96'(alarm), 96'(6'b000110));
    chk("temp_sample", 96'(sample[2*16 +: 16]), 96'(16'h1fff));

    thresh_hi[1*16 +: 16] = 16'hffff;
    start_poll();
    repeat (7) tick();
    chk("access_temp", 96'({apb.penable, apb.paddr}), 96'({1'b1, 8'h14}));
    alarm_clear = 1'b1;
    tick();
    alarm_clear = 1'b0;
    chk("set_wins", 96'(alarm), 96'(6'b000100));
    wait_done("alarm_b");
    chk("alarm_b", 96'(alarm), 96'(6'b000100));
    ovr_en = 1'b0;
    thresh_lo = '0; thresh_hi = '1;
`endif

    clear_flags();
    chk("cleared", 96'({alarm, bus_error}), 96'(0));

    // Slave error on vcore: sample kept, later channels still read.
    err_en = 1'b1; err_addr = 8'h16; data_ofs = 16'h0100;
    start_poll(); wait_done("slverr");
    chk("berr_slv", 96'(bus_error), 96'(6'b001000));
    chk("vcore_kept", 96'(sample[3*16 +: 16]), 96'(16'h1016));
    chk("after_err", 96'(sample[4*16 +: 32]), 96'({16'h111a, 16'h1118}));
    err_en = 1'b0;

    // Completer never answers fan1: 4 ACCESS cycles, then move on.
    clear_flags();
    chk("cleared2", 96'(bus_error), 96'(0));
    hang_en = 1'b1; hang_addr = 8'h12; data_ofs = 16'h0200;
    start_poll();
    repeat (3) tick();
    chk("hang_setup", 96'({apb.psel, apb.penable, apb.paddr}), 96'({2'b10, 8'h12}));
    repeat (4) tick();
    chk("hang_last_acc", 96'({apb.psel, apb.penable}), 96'(2'b11));
    tick();
    chk("hang_drop", 96'(apb.psel), 96'(0));
    tick();
    chk("hang_next", 96'({apb.psel, apb.penable, apb.paddr}), 96'({2'b10, 8'h14}));
    wait_done("timeout");
    chk("berr_to", 96'(bus_error), 96'(6'b000010));
    chk("fan1_kept", 96'(sample[1*16 +: 16]), 96'(16'h1112));
    chk("temp_new", 96'(sample[2*16 +: 16]), 96'(16'h1214));
    hang_en = 1'b0; data_ofs = 16'h0000;

    // Periodic start, poll_now mid-sweep, then enable dropped.
    clear_flags();
    enable = 1'b1;
    n = 0;
    while (apb.psel !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("auto_start", 96'(apb.psel), 96'(1));
    repeat (5) tick();
    poll_now = 1'b1;
    tick();
    poll_now = 1'b0;
    enable = 1'b0;
    n_done = 0; n_start = 0;
    for (int i = 0; i < 150; i++) begin
      if (sweep_done === 1'b1) n_done++;
      if (apb.psel === 1'b1 && apb.penable === 1'b0 && apb.paddr === 8'h10) n_start++;
      tick();
    end
    chk("n_sweeps", 96'(n_done), 96'(2));
    chk("n_restart", 96'(n_start), 96'(1));
    chk("final_idle", 96'({busy, apb.psel}), 96'(0));

    // Reset in the middle of a transfer.
    start_poll();
    tick();
    chk("pre_rst_acc", 96'({apb.psel, apb.penable}), 96'(2'b11));
    rst = 1'b1;
    tick();
    chk("rst_mid_apb", 96'({apb.psel, apb.penable, busy}), 96'(0));
    chk("rst_mid_data", 96'({sample_valid, alarm, bus_error}), 96'(0));
    chk("rst_mid_smp", sample, 96'(0));
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
